// File: rtl/mul_dot_accumulator_if.sv
// Product-in / result-out handshake bundle for the dot-product accumulator.
// The slave modport is the accumulator side; master is the producer/consumer side.
interface mul_dot_accumulator_if #(
    parameter int PW = 64,
    parameter int AW = 72,
    parameter int LW = 8
);
    logic          start;
    logic [LW-1:0] len;
    logic          prod_valid;
    logic          prod_ready;
    logic [PW-1:0] prod;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] acc_out;
    logic          overflow;
    logic          busy;

    modport slave (
        input  start, len, prod_valid, prod, out_ready,
        output prod_ready, out_valid, acc_out, overflow, busy
    );

    modport master (
        output start, len, prod_valid, prod, out_ready,
        input  prod_ready, out_valid, acc_out, overflow, busy
    );
endinterface

// File: rtl/mul_dot_accumulator.sv
// Sums a programmed number of unsigned multiplier products into a wide accumulator
// and hands the result out over a valid/ready handshake, with a sticky carry-out flag.
module mul_dot_accumulator #(
    parameter int PW = 64,
    parameter int AW = 72,
    parameter int LW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    mul_dot_accumulator_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t        state;
    logic [LW-1:0] cnt;
    logic [AW-1:0] acc;
    logic          ovf;
    logic          prod_ready;
    logic          out_valid;
    logic          busy;
    logic [AW:0]   sum;

    // One extra bit on the adder exposes the carry out of bit AW-1.
    always_comb begin
        sum = {1'b0, acc} + {{(AW + 1 - PW){1'b0}}, bus.prod};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            ovf        <= 1'b0;
            prod_ready <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc  <= '0;
                        ovf  <= 1'b0;
                        busy <= 1'b1;
                        if (bus.len != '0) begin
                            cnt        <= bus.len;
                            prod_ready <= 1'b1;
                            state      <= ACC;
                        end else begin
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                ACC: begin
                    // prod_ready is held high for the whole of ACC.
                    if (bus.prod_valid) begin
                        acc <= sum[AW-1:0];
                        ovf <= ovf | sum[AW];
                        cnt <= cnt - 1'b1;
                        if (cnt == LW'(1)) begin
                            prod_ready <= 1'b0;
                            out_valid  <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    prod_ready <= 1'b0;
                    out_valid  <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.prod_ready = prod_ready;
    assign bus.out_valid  = out_valid;
    assign bus.acc_out    = acc;
    assign bus.overflow   = ovf;
    assign bus.busy       = busy;
endmodule

// File: tb/tb_mul_dot_accumulator.sv
// Directed bench for mul_dot_accumulator with a result scoreboard and immediate assertions.
module tb_mul_dot_accumulator;
    localparam int PW = 64;
    localparam int AW = 65;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [AW:0] sb[$];

    always #5 clk = ~clk;

    mul_dot_accumulator_if #(.PW(PW), .AW(AW), .LW(LW)) bus ();

    mul_dot_accumulator #(.PW(PW), .AW(AW), .LW(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: AW-bit wrapping sum with sticky carry.
    task automatic model_push(input logic [PW-1:0] v[$]);
        logic [AW:0] s;
        logic        o;
        s = '0;
        o = 1'b0;
        foreach (v[i]) begin
            s = {1'b0, s[AW-1:0]} + {{(AW + 1 - PW){1'b0}}, v[i]};
            o = o | s[AW];
        end
        sb.push_back({o, s[AW-1:0]});
    endtask

    task automatic start_run(input int n);
        bus.start = 1'b1;
        bus.len   = LW'(n);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic feed(input logic [PW-1:0] v[$]);
        foreach (v[i]) begin
            bus.prod_valid = 1'b1;
            bus.prod       = v[i];
            tick();
        end
        bus.prod_valid = 1'b0;
    endtask

    task automatic collect(input string tag);
        int          k;
        logic [AW:0] e;
        k = 0;
        while (!bus.out_valid && k < 50) begin
            tick();
            k++;
        end
        if (!bus.out_valid || sb.size() == 0) begin
            chk({tag, "_timeout"}, {127'd0, bus.out_valid}, 128'd2);
        end else begin
            e = sb.pop_front();
            chk({tag, "_acc"}, 128'(bus.acc_out), 128'(e[AW-1:0]));
            chk({tag, "_ovf"}, 128'(bus.overflow), 128'(e[AW]));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_idle_busy"}, 128'(bus.busy), 128'd0);
        chk({tag, "_idle_valid"}, 128'(bus.out_valid), 128'd0);
    endtask

    initial begin
        logic [PW-1:0] v[$];
        logic [AW-1:0] held;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.len = '0;
        bus.prod_valid = 1'b0;
        bus.prod = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_prod_ready", 128'(bus.prod_ready), 128'd0);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_acc", 128'(bus.acc_out), 128'd0);
        chk("rst_ovf", 128'(bus.overflow), 128'd0);

        // Basic sum, back-to-back, out_valid exactly 4 cycles after start.
        v = '{64'h1_0000_0000, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF};
        model_push(v);
        chk("basic_model", 128'(sb[0]), 128'h1_0000_0001_0000_0004);
        start_run(3);
        chk("basic_busy", 128'(bus.busy), 128'd1);
        chk("basic_ready", 128'(bus.prod_ready), 128'd1);
        feed(v);
        chk("basic_latency", 128'(bus.out_valid), 128'd1);
        collect("basic");

        // Gapped input with backpressure on the result.
        model_push('{64'd7, 64'd9});
        start_run(2);
        bus.prod_valid = 1'b1; bus.prod = 64'd7; tick();
        bus.prod_valid = 1'b0; bus.prod = 64'd100; tick();
        tick();
        bus.prod_valid = 1'b1; bus.prod = 64'd9; tick();
        bus.prod_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 128'(bus.out_valid), 128'd1);
            chk("bp_acc", 128'(bus.acc_out), 128'd16);
            tick();
        end
        collect("gapped");
        chk("gapped_hold_acc", 128'(bus.acc_out), 128'd16);

        // Zero length: products offered throughout must be ignored.
        bus.prod_valid = 1'b1;
        bus.prod = 64'd123;
        sb.push_back('0);
        start_run(0);
        chk("zero_valid", 128'(bus.out_valid), 128'd1);
        chk("zero_ready", 128'(bus.prod_ready), 128'd0);
        collect("zero");
        chk("zero_ready_after", 128'(bus.prod_ready), 128'd0);
        bus.prod_valid = 1'b0;

        // Overflow boundary at AW=65.
        v = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        model_push(v);
        chk("ovf2_model", 128'(sb[0]), 128'h1_FFFF_FFFF_FFFF_FFFE);
        start_run(2);
        feed(v);
        collect("ovf2");
        v.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        model_push(v);
        chk("ovf3_model", 128'(sb[0]), 128'h2_FFFF_FFFF_FFFF_FFFD);
        start_run(3);
        feed(v);
        collect("ovf3");
        model_push('{64'd1});
        start_run(1);
        chk("ovf_cleared", 128'(bus.overflow), 128'd0);
        feed('{64'd1});
        collect("after_ovf");

        // Start pulsed during ACC is ignored.
        model_push('{64'd3, 64'd4});
        start_run(2);
        bus.start = 1'b1; bus.len = LW'(9);
        feed('{64'd3});
        bus.start = 1'b0;
        feed('{64'd4});
        chk("ign_done", 128'(bus.out_valid), 128'd1);
        chk("ign_ready", 128'(bus.prod_ready), 128'd0);
        collect("ignored");

        // Reset mid-ACC aborts with no result.
        start_run(4);
        feed('{64'd5});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 128'(bus.busy), 128'd0);
        chk("abort_ready", 128'(bus.prod_ready), 128'd0);
        chk("abort_acc", 128'(bus.acc_out), 128'd0);
        held = '0;
        for (int i = 0; i < 6; i++) begin
            held = held | AW'(bus.out_valid);
            tick();
        end
        chk("abort_no_valid", 128'(held), 128'd0);
        model_push('{64'd42});
        start_run(1);
        feed('{64'd42});
        collect("post_reset");

        chk("sb_drained", 128'(sb.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
